// File: rtl/cvxif_pkg.sv
// Shared types and sizing for the convolution control path (weight loader slice).
package cvxif_pkg;

    localparam int SA_ROWS   = 4;   // systolic array rows = weight rows per channel
    localparam int SA_COLS   = 4;   // weights per row word
    localparam int DATA_W    = 8;   // bits per weight
    localparam int ADDR_W    = 16;  // weight memory word address width
    localparam int CH_W      = 7;   // channel index width
    localparam int WL_ROWS_W = $clog2(SA_ROWS) + 1;  // holds 0..SA_ROWS inclusive

    typedef logic [SA_COLS*DATA_W-1:0] w_row_t;

    typedef enum logic [2:0] {
        WL_IDLE,
        WL_REQ,
        WL_WAIT,
        WL_SHIFT,
        WL_DONE
    } wl_state_e;

endpackage

// File: rtl/weight_loader_if.sv
// Bundle of control, weight-SRAM and array-side signals around the weight loader.
interface weight_loader_if;
    import cvxif_pkg::*;

    // control unit side
    logic                 start_w_load;
    logic [CH_W-1:0]      current_ch;
    logic [ADDR_W-1:0]    cfg_w_base;
    logic [WL_ROWS_W-1:0] cfg_rows;
    logic                 w_ended;
    logic                 busy;
    logic                 err;
    // weight SRAM port
    logic                 mem_req;
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_gnt;
    logic                 mem_rvalid;
    w_row_t               mem_rdata;
    // systolic array weight chain
    logic                 w_shift;
    w_row_t               w_data;

    // loader side
    modport master (
        input  start_w_load, current_ch, cfg_w_base, cfg_rows,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output mem_req, mem_addr,
        output w_shift, w_data, w_ended, busy, err
    );

    // environment side (control unit, memory, array)
    modport slave (
        output start_w_load, current_ch, cfg_w_base, cfg_rows,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  mem_req, mem_addr,
        input  w_shift, w_data, w_ended, busy, err
    );

endinterface

// File: rtl/weight_loader_addr_gen.sv
// Row counter plus weight address arithmetic for one channel load.
// Rows are walked from SA_ROWS-1 down to 0 so the last row enters the chain first.
module weight_addr_gen
    import cvxif_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 load,      // restart at the top row
    input  logic                 dec,       // step to the next lower row
    input  logic [CH_W-1:0]      ch,        // 0-based channel
    input  logic [ADDR_W-1:0]    base,
    input  logic [WL_ROWS_W-1:0] rows_eff,  // valid kernel rows, already sanitised
    output logic [ADDR_W-1:0]    addr,
    output logic                 last_row,
    output logic                 pad_row
);

    logic [WL_ROWS_W-1:0] r_q, r_d;

    // next row index: reload on a new load, count down on each consumed row
    always_comb begin
        r_d = r_q;
        if (load)
            r_d = WL_ROWS_W'(SA_ROWS - 1);
        else if (dec)
            r_d = r_q - WL_ROWS_W'(1);
    end

    // row counter register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_q <= '0;
        else         r_q <= r_d;
    end

    // address wraps modulo 2^ADDR_W by construction of the width
    assign addr     = base + ADDR_W'(ch) * ADDR_W'(SA_ROWS) + ADDR_W'(r_q);
    assign last_row = (r_q == '0);
    assign pad_row  = (r_q >= rows_eff);

endmodule

// File: rtl/weight_loader.sv
// Fetches one channel's kernel rows from weight SRAM and shifts them into the
// systolic array weight chain, last row first. Rows beyond cfg_rows are shifted
// in as zeros so the chain is always fully rewritten.
module weight_loader
    import cvxif_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rstn,
    weight_loader_if.master wl
);

    wl_state_e            state_q, state_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 w_ended_q, w_ended_d;
    w_row_t               w_data_q, w_data_d;
    logic                 start_q;

    logic                 trig;
    logic                 rows_bad;
    logic [WL_ROWS_W-1:0] rows_eff;
    logic                 row_load, row_dec;
    logic [ADDR_W-1:0]    row_addr;
    logic                 last_row, pad_row;

    assign trig     = wl.start_w_load & ~start_q;
    assign rows_bad = (wl.cfg_rows == '0) || (wl.cfg_rows > WL_ROWS_W'(SA_ROWS));
    assign rows_eff = rows_bad ? WL_ROWS_W'(SA_ROWS) : wl.cfg_rows;

    weight_addr_gen u_addr_gen (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .load     (row_load),
        .dec      (row_dec),
        .ch       (ch_q),
        .base     (wl.cfg_w_base),
        .rows_eff (rows_eff),
        .addr     (row_addr),
        .last_row (last_row),
        .pad_row  (pad_row)
    );

    // next-state logic for the load sequencer and its registered outputs
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        busy_d    = busy_q;
        err_d     = err_q;
        w_data_d  = w_data_q;
        w_ended_d = 1'b0;
        row_load  = 1'b0;
        row_dec   = 1'b0;

        // protocol violations are sticky until reset
        if (trig && state_q != WL_IDLE)           err_d = 1'b1;
        if (wl.mem_rvalid && state_q != WL_WAIT)  err_d = 1'b1;

        unique case (state_q)
            WL_IDLE: begin
                // busy drops the cycle after the done pulse
                if (w_ended_q) busy_d = 1'b0;
                if (trig) begin
                    busy_d   = 1'b1;
                    ch_d     = wl.current_ch - CH_W'(1);
                    row_load = 1'b1;
                    if (wl.current_ch == '0) begin
                        err_d   = 1'b1;
                        state_d = WL_DONE;
                    end else begin
                        if (rows_bad) err_d = 1'b1;
                        state_d = WL_REQ;
                    end
                end
            end
            WL_REQ: begin
                // padding rows shift a zero word in this cycle without memory
                if (pad_row) begin
                    if (last_row) state_d = WL_DONE;
                    else          row_dec = 1'b1;
                end else if (wl.mem_gnt) begin
                    state_d = WL_WAIT;
                end
            end
            WL_WAIT: begin
                if (wl.mem_rvalid) begin
                    w_data_d = wl.mem_rdata;
                    state_d  = WL_SHIFT;
                end
            end
            WL_SHIFT: begin
                w_data_d = '0;
                if (last_row) begin
                    state_d = WL_DONE;
                end else begin
                    row_dec = 1'b1;
                    state_d = WL_REQ;
                end
            end
            WL_DONE: begin
                w_ended_d = 1'b1;
                state_d   = WL_IDLE;
            end
            default: state_d = WL_IDLE;
        endcase
    end

    // sequencer state, edge detector and registered outputs
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= WL_IDLE;
            ch_q      <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            w_ended_q <= 1'b0;
            w_data_q  <= '0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            w_ended_q <= w_ended_d;
            w_data_q  <= w_data_d;
            start_q   <= wl.start_w_load;
        end
    end

    // request and shift strobes decode straight from state so reset kills them at once
    assign wl.mem_req  = (state_q == WL_REQ) && !pad_row;
    assign wl.mem_addr = wl.mem_req ? row_addr : '0;
    assign wl.w_shift  = (state_q == WL_SHIFT) || ((state_q == WL_REQ) && pad_row);
    assign wl.w_data   = w_data_q;
    assign wl.w_ended  = w_ended_q;
    assign wl.busy     = busy_q;
    assign wl.err      = err_q;

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: a memory responder with configurable
// stalls, a per-load expectation model, and a per-cycle output compare.
module tb_weight_loader;
    import cvxif_pkg::*;

    logic i_clk  = 1'b0;
    logic i_rstn = 1'b0;

    weight_loader_if wl();

    weight_loader dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .wl     (wl)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_pass = 0;
    int ended_cnt = 0;

    logic [ADDR_W-1:0] exp_addr[$];
    logic [ADDR_W-1:0] addr_log[$];
    w_row_t            exp_shift[$];
    w_row_t            shift_log[$];

    int max_stall = 0;
    int max_lat   = 0;
    bit hold_gnt  = 0;
    bit req_act   = 0;
    bit pend      = 0;
    int stall_cnt = 0;
    int lat_cnt   = 0;
    logic [ADDR_W-1:0] pend_addr;

    // memory content: any address maps to a distinct non-zero word
    function automatic w_row_t mem_fn(input logic [ADDR_W-1:0] a);
        return {~a, a + 16'h1234};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    // expected SRAM addresses and shifted words for one accepted load
    task automatic push_exp(input int ch, input logic [ADDR_W-1:0] base, input int rows);
        int re;
        logic [ADDR_W-1:0] a;
        re = (rows == 0 || rows > SA_ROWS) ? SA_ROWS : rows;
        for (int r = SA_ROWS - 1; r >= 0; r--) begin
            if (r >= re) begin
                exp_shift.push_back('0);
            end else begin
                a = base + ADDR_W'((ch - 1) * SA_ROWS + r);
                exp_addr.push_back(a);
                exp_shift.push_back(mem_fn(a));
            end
        end
    endtask

    // memory responder: random grant stall per request, random read latency
    initial begin
        wl.mem_gnt    = 1'b0;
        wl.mem_rvalid = 1'b0;
        wl.mem_rdata  = '0;
        forever begin
            @(posedge i_clk); #1;
            wl.mem_gnt    = 1'b0;
            wl.mem_rvalid = 1'b0;
            wl.mem_rdata  = $urandom;
            if (pend) begin
                if (lat_cnt == 0) begin
                    wl.mem_rvalid = 1'b1;
                    wl.mem_rdata  = mem_fn(pend_addr);
                    pend = 0;
                end else lat_cnt--;
            end
            if (wl.mem_req && !req_act && !pend) begin
                req_act   = 1;
                stall_cnt = $urandom_range(max_stall, 0);
            end
            if (req_act && !hold_gnt) begin
                if (stall_cnt == 0) begin
                    wl.mem_gnt = 1'b1;
                    req_act    = 0;
                    pend       = 1;
                    pend_addr  = wl.mem_addr;
                    lat_cnt    = $urandom_range(max_lat, 0);
                end else stall_cnt--;
            end
        end
    end

    // per-cycle compare against the expectation queues
    logic              prev_hold = 1'b0, prev_shift = 1'b0, prev_end = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    always @(negedge i_clk) begin
        if (!i_rstn) begin
            prev_hold  <= 1'b0;
            prev_shift <= 1'b0;
            prev_end   <= 1'b0;
        end else begin
            if (prev_hold) begin
                chk("req_hold", wl.mem_req, 1);
                chk("addr_hold", wl.mem_addr, prev_addr);
            end
            if (wl.mem_req && wl.mem_gnt) begin
                addr_log.push_back(wl.mem_addr);
                if (exp_addr.size() == 0) chk("unexpected_req", 1, 0);
                else chk("mem_addr", wl.mem_addr, exp_addr.pop_front());
            end
            if (wl.w_shift) begin
                shift_log.push_back(wl.w_data);
                if (exp_shift.size() == 0) chk("unexpected_shift", 1, 0);
                else chk("shift_data", wl.w_data, exp_shift.pop_front());
            end else if (prev_shift && exp_shift.size() == 0) begin
                chk("w_data_clr", wl.w_data, 0);
            end
            if (wl.w_ended) chk("busy_at_end", wl.busy, 1);
            if (prev_end) chk("busy_after_end", wl.busy, 0);
            if (wl.w_ended) ended_cnt <= ended_cnt + 1;
            prev_hold  <= wl.mem_req && !wl.mem_gnt;
            prev_addr  <= wl.mem_addr;
            prev_shift <= wl.w_shift;
            prev_end   <= wl.w_ended;
        end
    end

    task automatic trigger(input int ch, input logic [ADDR_W-1:0] base, input int rows, input bit expect_load);
        @(posedge i_clk); #1;
        wl.cfg_w_base   = base;
        wl.cfg_rows     = WL_ROWS_W'(rows);
        wl.current_ch   = CH_W'(ch);
        wl.start_w_load = 1'b1;
        if (expect_load) push_exp(ch, base, rows);
    endtask

    task automatic release_start();
        @(posedge i_clk); #1;
        wl.start_w_load = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        int e0;
        int c;
        e0 = ended_cnt;
        c  = 0;
        while (ended_cnt == e0 && c < 500) begin
            @(posedge i_clk);
            c++;
        end
        chk(nm, (ended_cnt != e0), 1);
        repeat (2) @(posedge i_clk);
    endtask

    task automatic clear_logs();
        addr_log.delete();
        shift_log.delete();
    endtask

    task automatic pulse_reset();
        @(posedge i_clk); #3;
        i_rstn   = 1'b0;
        hold_gnt = 1;
        #1;
        chk("rst_mem_req", wl.mem_req, 0);
        chk("rst_w_shift", wl.w_shift, 0);
        chk("rst_busy", wl.busy, 0);
        chk("rst_w_ended", wl.w_ended, 0);
        wl.start_w_load = 1'b0;
        exp_addr.delete();
        exp_shift.delete();
        req_act = 0;
        pend    = 0;
        @(posedge i_clk); #3;
        i_rstn   = 1'b1;
        hold_gnt = 0;
        chk("rst_err", wl.err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        wl.start_w_load = 1'b0;
        wl.current_ch   = '0;
        wl.cfg_w_base   = '0;
        wl.cfg_rows     = WL_ROWS_W'(4);

        // reset state
        repeat (2) @(posedge i_clk); #1;
        chk("reset_mem_req", wl.mem_req, 0);
        chk("reset_mem_addr", wl.mem_addr, 0);
        chk("reset_w_shift", wl.w_shift, 0);
        chk("reset_w_data", wl.w_data, 0);
        chk("reset_w_ended", wl.w_ended, 0);
        chk("reset_busy", wl.busy, 0);
        chk("reset_err", wl.err, 0);
        @(posedge i_clk); #3;
        i_rstn = 1'b1;

        // zero-wait memory, full rows, channel 3 at base 0x100
        clear_logs();
        e0 = ended_cnt;
        trigger(3, 16'h0100, 4, 1);
        release_start();
        wait_end("t1_done");
        chk("t1_nfetch", addr_log.size(), 4);
        chk("t1_addr0", addr_log[0], 16'h010B);
        chk("t1_addr1", addr_log[1], 16'h010A);
        chk("t1_addr2", addr_log[2], 16'h0109);
        chk("t1_addr3", addr_log[3], 16'h0108);
        chk("t1_nshift", shift_log.size(), 4);
        chk("t1_data0", shift_log[0], 32'hFEF4133F);
        chk("t1_ended_once", ended_cnt - e0, 1);
        chk("t1_exp_empty", exp_shift.size() + exp_addr.size(), 0);
        chk("t1_err", wl.err, 0);

        // two valid rows: top two shifts are padding
        clear_logs();
        trigger(1, 16'h0000, 2, 1);
        release_start();
        wait_end("t2_done");
        chk("t2_nfetch", addr_log.size(), 2);
        chk("t2_addr0", addr_log[0], 16'h0001);
        chk("t2_addr1", addr_log[1], 16'h0000);
        chk("t2_nshift", shift_log.size(), 4);
        chk("t2_pad0", shift_log[0], 0);
        chk("t2_pad1", shift_log[1], 0);
        chk("t2_data2", shift_log[2], 32'hFFFE1235);
        chk("t2_err", wl.err, 0);

        // grant and read stalls, including an address that wraps
        max_stall = 5;
        max_lat   = 5;
        clear_logs();
        trigger(5, 16'h2000, 3, 1);
        release_start();
        wait_end("t3a_done");
        trigger(7, 16'hFFF0, 4, 1);
        release_start();
        wait_end("t3b_done");
        chk("t3_nfetch", addr_log.size(), 7);
        chk("t3_wrap_addr", addr_log[3], 16'h000B);
        chk("t3_nshift", shift_log.size(), 8);
        chk("t3_err", wl.err, 0);
        max_stall = 0;
        max_lat   = 0;

        // level held across done, second edge while busy
        clear_logs();
        e0 = ended_cnt;
        trigger(4, 16'h0040, 4, 1);
        repeat (4) @(posedge i_clk); #1;
        wl.start_w_load = 1'b0;
        @(posedge i_clk); #1;
        wl.start_w_load = 1'b1;
        wait_end("t4a_done");
        chk("t4_err_busy_edge", wl.err, 1);
        repeat (4) @(posedge i_clk); #1;
        chk("t4_no_retrigger", wl.busy, 0);
        chk("t4_one_end", ended_cnt - e0, 1);
        chk("t4a_nfetch", addr_log.size(), 4);
        wl.start_w_load = 1'b0;
        trigger(2, 16'h0040, 4, 1);
        release_start();
        wait_end("t4b_done");
        chk("t4_two_ends", ended_cnt - e0, 2);
        chk("t4b_addr0", addr_log[4], 16'h0047);
        chk("t4_err_sticky", wl.err, 1);

        // channel 0: error, no memory traffic, done two cycles later
        pulse_reset();
        @(posedge i_clk); #1;
        wl.current_ch   = '0;
        wl.start_w_load = 1'b1;
        @(negedge i_clk);
        chk("t5_end_n0", wl.w_ended, 0);
        @(negedge i_clk);
        chk("t5_end_n1", wl.w_ended, 0);
        chk("t5_busy_n1", wl.busy, 1);
        @(negedge i_clk);
        chk("t5_end_n2", wl.w_ended, 1);
        chk("t5_err", wl.err, 1);
        chk("t5_no_req", wl.mem_req, 0);
        @(negedge i_clk);
        chk("t5_end_n3", wl.w_ended, 0);
        chk("t5_busy_n3", wl.busy, 0);
        wl.start_w_load = 1'b0;

        // cfg_rows out of range behaves as full rows and flags error
        pulse_reset();
        clear_logs();
        trigger(1, 16'h0010, 0, 1);
        release_start();
        wait_end("t6_done");
        chk("t6_nfetch", addr_log.size(), 4);
        chk("t6_err", wl.err, 1);

        // reset while a request is pending, then a clean load
        pulse_reset();
        hold_gnt = 1;
        trigger(6, 16'h0300, 4, 1);
        release_start();
        repeat (2) @(posedge i_clk); #1;
        chk("t7_req_pending", wl.mem_req, 1);
        pulse_reset();
        clear_logs();
        trigger(2, 16'h0300, 4, 1);
        release_start();
        wait_end("t7_done");
        chk("t7_nfetch", addr_log.size(), 4);
        chk("t7_addr0", addr_log[0], 16'h0307);
        chk("t7_nshift", shift_log.size(), 4);
        chk("t7_err", wl.err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Downstream stage of the convolution control unit.
- On each weight-load request, fetches the kernel-weight rows for the requested input channel from weight memory and shifts them into the systolic array's weight registers, last row first.
- Signals completion with a single-cycle w_ended pulse, which the control unit uses to drop its load request.
- Sits between the control unit, the weight SRAM port and the systolic array.

Parameters:
- SA_ROWS, 4, systolic array rows (weight rows per channel).
- SA_COLS, 4, systolic array columns (weights per row word).
- DATA_W, 8, bits per weight.
- ADDR_W, 16, weight memory word-address width.
- CH_W, 7, channel index width.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- start_w_load  in  1  load request from the control unit (level; a load is triggered on its rising edge).
- current_ch  in  CH_W  1-based input channel to load; sampled on the trigger.
- cfg_w_base  in  ADDR_W  word address of channel 1, row 0.
- cfg_rows  in  $clog2(SA_ROWS)+1  valid kernel rows, 1..SA_ROWS.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  read address.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  SA_COLS*DATA_W  one weight row.
- w_shift  out  1  shift enable to the array weight chain.
- w_data  out  SA_COLS*DATA_W  row being shifted in.
- w_ended  out  1  one-cycle done pulse.
- busy  out  1  high from trigger until w_ended.
- err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, edge-detect register 0.
  - Reset asserted mid-load abandons the load immediately; mem_req drops asynchronously.
- Trigger: start_w_load==1 while its registered previous value==0.
  - A trigger outside IDLE is ignored and sets err.
- FSM states: IDLE, REQ, WAIT, SHIFT, DONE.
- IDLE -> REQ on trigger. The trigger cycle also does the following:
  - latches ch = current_ch - 1;
  - sets row counter r = SA_ROWS-1;
  - asserts busy.
- current_ch == 0 on trigger: set err, go IDLE -> DONE directly. No memory access, no shifts.
- REQ:
  - If r >= cfg_rows: the row is padding. w_data = 0, w_shift = 1 this cycle, no memory access. Then r--, or go to DONE if r was 0.
  - Otherwise: mem_req = 1, mem_addr = cfg_w_base + ch*SA_ROWS + r, computed modulo 2^ADDR_W.
  - mem_req and mem_addr are held stable until mem_gnt. Move to WAIT on the cycle mem_gnt is sampled high.
- WAIT: on mem_rvalid, register mem_rdata into w_data, go to SHIFT. Data may arrive 1..N cycles after grant. One outstanding request at most.
- SHIFT: w_shift = 1 for exactly one cycle with the registered w_data. Then r--, back to REQ; or go to DONE if r was 0.
- Latency per fetched row: grant cycle + read latency + 1 shift cycle. Shifts are at least 2 cycles apart when memory has zero wait states.
- DONE: w_ended = 1 for one cycle, busy = 0 next cycle, return to IDLE.
  - A start_w_load that is still high in DONE/IDLE is not re-triggered; a new rising edge is required.
- cfg_w_base and cfg_rows must be stable while busy; they are not re-sampled.
- cfg_rows == 0 or > SA_ROWS: set err, treat as SA_ROWS.
- Exactly SA_ROWS shifts occur per valid load, so the array chain is always fully rewritten.
- w_data returns to 0 on the cycle after the final shift.
- mem_rvalid seen outside WAIT sets err; the data is discarded.

Decomposition:
- cvxif_pkg gains:
  - wl_state_e, the FSM enum;
  - typedef w_row_t, logic [SA_COLS*DATA_W-1:0];
  - localparam WL_ROWS_W.
- One sub-module: weight_addr_gen. It holds the row counter and computes mem_addr from ch, r and base, and exposes last_row and pad_row flags.
- The FSM and handshake stay in weight_loader.

Test Plan:
- Zero-wait memory (gnt same cycle, rvalid next), cfg_w_base=0x0100, cfg_rows=4, current_ch=3 -> addresses 0x010B, 0x010A, 0x0109, 0x0108 in that order; 4 w_shift pulses carrying matching rdata; w_ended pulses exactly once; busy low the following cycle.
- cfg_rows=2, current_ch=1, base 0 -> first 2 shifts carry zero data with no mem_req, then rows addr 1 and 0 are fetched; 4 shifts total.
- Random gnt/rvalid stalls of 0..5 cycles -> mem_addr is stable while mem_req && !mem_gnt; row order and data are unchanged; no double shift.
- start_w_load held high across w_ended, dropped, then re-raised with current_ch=2 -> exactly one load per rising edge; the second load uses ch=2. A second rising edge while busy sets err and does not disturb the load in progress.
- current_ch=0 -> err=1, no mem_req, w_ended pulses 2 cycles after the trigger.
- i_rstn pulsed low during WAIT with mem_req pending -> mem_req, w_shift, busy, w_ended go 0 immediately; the next trigger performs a clean full load.
